// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN layer engines (max-pool stage).
package cnn_pkg;

  localparam int DATA_W = 20;
  localparam int IMG_W  = 64;
  localparam int ADDR_W = 12;

  localparam logic [2:0] CSEL_IDLE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  // IDLE -> RD (k = 0..3) -> WR -> ... -> DONE -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } pool_state_e;

endpackage

// File: rtl/maxpool_engine_if.sv
// Memory-side bus of the max-pool engine: layer-0 read port, layer-1 write port, select.
interface maxpool_engine_if;
  import cnn_pkg::*;

  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic [2:0]        csel;

  // engine side
  modport master (
    output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    input  cdata_rd
  );

  // memory side
  modport slave (
    input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    output cdata_rd
  );

endinterface

// File: rtl/pool_addr_gen.sv
// Layer-0 read address for output index o and 2x2 window step k.
// With IMG_W a power of two, base + {0, 1, IMG_W, IMG_W+1}[k] equals the
// bit splice {row, k[1], col, k[0]}: pixel row 2r+k[1], pixel column 2c+k[0].
module pool_addr_gen #(
  parameter int IMG_W  = cnn_pkg::IMG_W,
  parameter int C_BITS = $clog2(IMG_W / 2)
) (
  input  logic [2*C_BITS-1:0]      i_o,
  input  logic [1:0]               i_k,
  output logic [cnn_pkg::ADDR_W-1:0] o_addr
);
  import cnn_pkg::*;

  logic [C_BITS-1:0]   w_row;
  logic [C_BITS-1:0]   w_col;
  logic [2*C_BITS+1:0] w_flat;

  assign w_row  = i_o[2*C_BITS-1:C_BITS];
  assign w_col  = i_o[C_BITS-1:0];
  assign w_flat = {w_row, i_k[1], w_col, i_k[0]};
  assign o_addr = ADDR_W'(w_flat);

endmodule

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 max-pool over one layer-0 frame into layer-1 memory.
// Each output costs four read cycles and one write cycle; all bus outputs are
// registered and computed from the next state so they line up with the state.
module maxpool_engine #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IMG_W  = cnn_pkg::IMG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  maxpool_engine_if.master mem
);
  import cnn_pkg::*;

  localparam int C_BITS = $clog2(IMG_W / 2);
  localparam int O_BITS = 2 * C_BITS;
  localparam logic [O_BITS-1:0] O_LAST = {O_BITS{1'b1}};

  pool_state_e       r_state, w_state_nxt;
  logic [O_BITS-1:0] r_o, w_o_nxt;
  logic [1:0]        r_k, w_k_nxt;
  logic [DATA_W-1:0] r_max, w_max_nxt;
  logic [ADDR_W-1:0] w_addr_rd;

  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_crd, w_crd_nxt;
  logic              r_cwr, w_cwr_nxt;
  logic [2:0]        r_csel, w_csel_nxt;
  logic [ADDR_W-1:0] r_caddr_rd, w_caddr_rd_nxt;
  logic [ADDR_W-1:0] r_caddr_wr, w_caddr_wr_nxt;
  logic [DATA_W-1:0] r_cdata_wr, w_cdata_wr_nxt;

  // Address of the window pixel that will be read in the next cycle.
  pool_addr_gen #(.IMG_W(IMG_W), .C_BITS(C_BITS)) u_addr_gen (
    .i_o    (w_o_nxt),
    .i_k    (w_k_nxt),
    .o_addr (w_addr_rd)
  );

  // Next state and window/output counters.
  always_comb begin
    w_state_nxt = r_state;
    w_o_nxt     = r_o;
    w_k_nxt     = r_k;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RD;
          w_o_nxt     = '0;
          w_k_nxt     = 2'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        if (r_k == 2'd3) begin
          w_state_nxt = ST_WR;
        end else begin
          w_k_nxt = r_k + 2'd1;
        end
      end
      ST_WR: begin
        w_k_nxt = 2'd0;
        if (r_o == O_LAST) begin
          w_state_nxt = ST_DONE;
          w_o_nxt     = '0;
        end else begin
          w_state_nxt = ST_RD;
          w_o_nxt     = r_o + O_BITS'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_o_nxt     = '0;
        w_k_nxt     = 2'd0;
      end
    endcase
  end

  // Running maximum: load on k=0, replace only on a strictly greater unsigned value.
  always_comb begin
    w_max_nxt = r_max;
    if (r_state == ST_RD) begin
      if (r_k == 2'd0) begin
        w_max_nxt = mem.cdata_rd;
      end else if (mem.cdata_rd > r_max) begin
        w_max_nxt = mem.cdata_rd;
      end else begin
        w_max_nxt = r_max;
      end
    end else begin
      w_max_nxt = r_max;
    end
  end

  // Output values for the cycle that the next state occupies.
  always_comb begin
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_crd_nxt      = 1'b0;
    w_cwr_nxt      = 1'b0;
    w_csel_nxt     = CSEL_IDLE;
    w_caddr_rd_nxt = '0;
    w_caddr_wr_nxt = '0;
    w_cdata_wr_nxt = '0;
    case (w_state_nxt)
      ST_RD: begin
        w_busy_nxt     = 1'b1;
        w_crd_nxt      = 1'b1;
        w_csel_nxt     = CSEL_L0;
        w_caddr_rd_nxt = w_addr_rd;
      end
      ST_WR: begin
        w_busy_nxt     = 1'b1;
        w_cwr_nxt      = 1'b1;
        w_csel_nxt     = CSEL_L1;
        w_caddr_wr_nxt = ADDR_W'(w_o_nxt);
        w_cdata_wr_nxt = w_max_nxt;
      end
      ST_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // State, counters, running max and registered outputs; reset aborts at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_o        <= '0;
      r_k        <= 2'd0;
      r_max      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_csel     <= CSEL_IDLE;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_o        <= w_o_nxt;
      r_k        <= w_k_nxt;
      r_max      <= w_max_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_crd      <= w_crd_nxt;
      r_cwr      <= w_cwr_nxt;
      r_csel     <= w_csel_nxt;
      r_caddr_rd <= w_caddr_rd_nxt;
      r_caddr_wr <= w_caddr_wr_nxt;
      r_cdata_wr <= w_cdata_wr_nxt;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign mem.crd      = r_crd;
  assign mem.cwr      = r_cwr;
  assign mem.csel     = r_csel;
  assign mem.caddr_rd = r_caddr_rd;
  assign mem.caddr_wr = r_caddr_wr;
  assign mem.cdata_wr = r_cdata_wr;

endmodule

// File: doc/maxpool_engine.md
MAXPOOL_ENGINE -- requirements
Module: maxpool_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 20, meaning pixel width of layer-0 and layer-1 data.
REQ-002 The block SHALL have parameter IMG_W, default 64, meaning layer-0 frame width and height in pixels (power of two).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  meaning request to pool one full frame, sampled in IDLE only.
REQ-006 The block SHALL have port busy  output  1  meaning a frame is in progress.
REQ-007 The block SHALL have port done  output  1  meaning a one-cycle pulse when the frame is complete.
REQ-008 The block SHALL have port crd  output  1  meaning a layer-0 memory read strobe.
REQ-009 The block SHALL have port caddr_rd  output  12  meaning the layer-0 read address.
REQ-010 The block SHALL have port cdata_rd  input  DATA_W  meaning layer-0 read data, valid at the rising edge that ends the cycle in which crd/caddr_rd were driven.
REQ-011 The block SHALL have port cwr  output  1  meaning a layer-1 write strobe, sampled by memory on the rising edge.
REQ-012 The block SHALL have port caddr_wr  output  12  meaning the layer-1 write address.
REQ-013 The block SHALL have port cdata_wr  output  DATA_W  meaning layer-1 write data.
REQ-014 The block SHALL have port csel  output  3  meaning memory select: 3'b001 = layer 0 (read), 3'b011 = layer 1 (write), 3'b000 = idle.

Function
REQ-015 The FSM SHALL have states IDLE, RD (4 sub-steps k=0..3), WR and DONE.
REQ-016 IDLE -> RD(k=0) SHALL occur on the rising edge where start=1; busy SHALL be high from the following cycle until DONE.
REQ-017 For output index o={r[4:0],c[4:0]} (IMG_W=64), RD step k SHALL drive crd=1, csel=001, caddr_rd = base + {0, 1, IMG_W, IMG_W+1}[k], base=(2r)*IMG_W+2c.
REQ-018 At the end of RD k=0 the running max SHALL load cdata_rd; at k=1..3 it SHALL take cdata_rd only if strictly greater (unsigned DATA_W compare; ties keep the earlier value).
REQ-019 WR SHALL drive cwr=1, csel=011, caddr_wr={2'b00,o}, cdata_wr=running max, crd=0, for exactly one cycle.
REQ-020 Each output SHALL take exactly 5 cycles (4 RD + 1 WR); outputs SHALL be produced in raster order o=0..1023 with no gaps, for 5120 busy cycles total.
REQ-021 After the WR for o=1023 the FSM SHALL enter DONE for one cycle: done=1, busy=0; it SHALL then return to IDLE.
REQ-022 start asserted while busy or in DONE SHALL be ignored; start held high in IDLE SHALL launch a new frame.
REQ-023 crd and cwr SHALL never be high in the same cycle; in IDLE/DONE crd=cwr=0 and csel=000.
REQ-024 Output and row counters SHALL wrap o 1023->0 only at frame end; caddr_rd SHALL never exceed IMG_W*IMG_W-1.

Reset
REQ-025 While reset=0, all outputs SHALL be 0 (busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr), the state SHALL be IDLE, and counters and the running max SHALL be 0.
REQ-026 Reset mid-frame SHALL abort immediately with no further writes; a later start SHALL restart at o=0.

Structure
REQ-027 Shared package cnn_pkg SHALL hold DATA_W, IMG_W, CSEL_L0=3'b001, CSEL_L1=3'b011 and the FSM state enum.
REQ-028 Address arithmetic SHALL be isolated in one sub-module pool_addr_gen (o, k -> caddr_rd); the comparator stays inline.

Verification
REQ-029 Reset held low 3 cycles -> all outputs 0; release with start=0 -> busy stays 0.
REQ-030 L0[a]=a for all a, start pulse -> L1[0]=0x041, L1[1]=0x043, L1[1023]=0xFFF; busy high exactly 5120 cycles; one done pulse.
REQ-031 Block 0 = {5,9,3,7} -> L1[0]=9; block 1 = {8,8,8,8} -> L1[1]=8; max at k=3 {1,2,3,0x0ABCD} -> 0x0ABCD.
REQ-032 Unsigned compare: block 0 = {0x7FFFF,0xFFFFF,0,1} -> L1[0]=0xFFFFF.
REQ-033 Reset low during WR of o=500 -> cwr=0 the same cycle, busy=0; restart -> full frame correct, writes start at caddr_wr=0.
REQ-034 start pulsed at cycles 100 and 3000 of a frame -> ignored; exactly 1024 writes and one done pulse.
